// File: rtl/uart_msg_ctrl.sv
// Frame-level UART message controller: round-robin TX framing of two requesters and RX frame reassembly.
// Optional checksum byte enabled by defining UART_MSG_CHKSUM_EN.
module uart_msg_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 65000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_tag0,
    input  logic [7:0] req_tag1,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       wr_uart,
    output logic [7:0] w_data,
    input  logic       tx_full,
    output logic       rd_uart,
    input  logic [7:0] r_data,
    input  logic       rx_empty,
    output logic       rx_valid,
    output logic [7:0] rx_tag,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_TAG, TX_DATA, TX_CHK} tx_state_e;
    typedef enum logic [1:0] {RX_HUNT, RX_TAG, RX_DATA, RX_CHK} rx_state_e;

`ifdef UART_MSG_CHKSUM_EN
    function automatic logic [7:0] frame_chk(input logic [7:0] tag, input logic [7:0] data);
        return SYNC_BYTE ^ tag ^ data;
    endfunction
`endif

    tx_state_e        tx_state_q, tx_state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [7:0]       tx_tag_q, tx_tag_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       w_data_q, w_data_d;
    logic             grant_s;
    logic             tx_idle_s;
    logic             accept_s;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sh_tag_q, sh_tag_d;
`ifdef UART_MSG_CHKSUM_EN
    logic [7:0]       sh_data_q, sh_data_d;
`endif
    logic [7:0]       rx_tag_q, rx_tag_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;
    logic             timeout_s;

    // Round-robin grant: on a tie the requester not served last wins
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~rr_ptr_q;
            default: grant_s = 1'b0;
        endcase
    end

    assign tx_idle_s = (tx_state_q == TX_IDLE) && !reset;
    assign req_ready = {tx_idle_s & req_valid[1] & grant_s, tx_idle_s & req_valid[0] & ~grant_s};
    assign accept_s  = |req_ready;
    assign wr_uart   = (tx_state_q != TX_IDLE) && !tx_full && !reset;
    assign w_data    = w_data_q;

    // TX next state: w_data is preloaded one state ahead so it is stable during stalls
    always_comb begin
        tx_state_d = tx_state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_tag_d   = tx_tag_q;
        tx_data_d  = tx_data_q;
        w_data_d   = w_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (accept_s) begin
                    tx_tag_d   = grant_s ? req_tag1 : req_tag0;
                    tx_data_d  = grant_s ? req_data1 : req_data0;
                    rr_ptr_d   = grant_s;
                    w_data_d   = SYNC_BYTE;
                    tx_state_d = TX_SYNC;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_SYNC: begin
                if (wr_uart) begin
                    w_data_d   = tx_tag_q;
                    tx_state_d = TX_TAG;
                end else begin
                    tx_state_d = TX_SYNC;
                end
            end
            TX_TAG: begin
                if (wr_uart) begin
                    w_data_d   = tx_data_q;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_TAG;
                end
            end
            TX_DATA: begin
                if (wr_uart) begin
`ifdef UART_MSG_CHKSUM_EN
                    w_data_d   = frame_chk(tx_tag_q, tx_data_q);
                    tx_state_d = TX_CHK;
`else
                    tx_state_d = TX_IDLE;
`endif
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_CHK: begin
                if (wr_uart) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_CHK;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            rr_ptr_q   <= 1'b1;
            tx_tag_q   <= 8'h00;
            tx_data_q  <= 8'h00;
            w_data_q   <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_tag_q   <= tx_tag_d;
            tx_data_q  <= tx_data_d;
            w_data_q   <= w_data_d;
        end
    end

    assign rd_uart   = !rx_empty && !reset;
    assign timeout_s = (rx_state_q != RX_HUNT) && !rd_uart && (cnt_q == CNT_MAX);
    assign rx_valid  = rx_valid_q;
    assign rx_err    = rx_err_q;
    assign rx_tag    = rx_tag_q;
    assign rx_data   = rx_data_q;

    // RX next state: a byte popped in the expiry cycle takes priority over the timeout
    always_comb begin
        rx_state_d = rx_state_q;
        sh_tag_d   = sh_tag_q;
`ifdef UART_MSG_CHKSUM_EN
        sh_data_d  = sh_data_q;
`endif
        rx_tag_d   = rx_tag_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (rd_uart || timeout_s || (rx_state_q == RX_HUNT)) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (rx_state_q)
            RX_HUNT: begin
                if (rd_uart && (r_data == SYNC_BYTE)) begin
                    rx_state_d = RX_TAG;
                end else begin
                    rx_state_d = RX_HUNT;
                end
            end
            RX_TAG: begin
                if (rd_uart) begin
                    sh_tag_d   = r_data;
                    rx_state_d = RX_DATA;
                end else if (timeout_s) begin
                    rx_err_d   = 1'b1;
                    rx_state_d = RX_HUNT;
                end else begin
                    rx_state_d = RX_TAG;
                end
            end
            RX_DATA: begin
                if (rd_uart) begin
`ifdef UART_MSG_CHKSUM_EN
                    sh_data_d  = r_data;
                    rx_state_d = RX_CHK;
`else
                    rx_tag_d   = sh_tag_q;
                    rx_data_d  = r_data;
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_HUNT;
`endif
                end else if (timeout_s) begin
                    rx_err_d   = 1'b1;
                    rx_state_d = RX_HUNT;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_CHK: begin
`ifdef UART_MSG_CHKSUM_EN
                if (rd_uart) begin
                    if (r_data == frame_chk(sh_tag_q, sh_data_q)) begin
                        rx_tag_d   = sh_tag_q;
                        rx_data_d  = sh_data_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d   = 1'b1;
                    end
                    rx_state_d = RX_HUNT;
                end else if (timeout_s) begin
                    rx_err_d   = 1'b1;
                    rx_state_d = RX_HUNT;
                end else begin
                    rx_state_d = RX_CHK;
                end
`else
                rx_state_d = RX_HUNT;
`endif
            end
            default: rx_state_d = RX_HUNT;
        endcase
    end

    // RX registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_HUNT;
            cnt_q      <= {CNT_W{1'b0}};
            sh_tag_q   <= 8'h00;
`ifdef UART_MSG_CHKSUM_EN
            sh_data_q  <= 8'h00;
`endif
            rx_tag_q   <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            sh_tag_q   <= sh_tag_d;
`ifdef UART_MSG_CHKSUM_EN
            sh_data_q  <= sh_data_d;
`endif
            rx_tag_q   <= rx_tag_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Randomized self-checking bench for uart_msg_ctrl against a frame-level reference model.
// Honours UART_MSG_CHKSUM_EN the same way as the design.
module tb_uart_msg_ctrl;

    localparam int         TO   = 40;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_MSG_CHKSUM_EN
    localparam int         FLEN = 4;
`else
    localparam int         FLEN = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_tag0, req_tag1, req_data0, req_data1;
    logic [1:0] req_ready;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full;
    logic       rd_uart;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_valid;
    logic [7:0] rx_tag, rx_data;
    logic       rx_err;

    uart_msg_ctrl #(.TIMEOUT_CYC(TO), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_tag0(req_tag0), .req_tag1(req_tag1), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .rx_valid(rx_valid), .rx_tag(rx_tag), .rx_data(rx_data), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] txq[$];
    int         tx_pend = 0;
    logic       last_gnt = 1'b1;
    int         gnt_log[$];
    logic [7:0] rx_b[$];
    int         rx_g[$];
    logic [7:0] fbuf[$];
    int         in_frame = 0;
    int         idle_cnt = 0;
    logic       exp_valid = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_tag = 8'h00, exp_data = 8'h00;
    int         wchk_zero = 0;
    int         acc_flag = 0;
    int         cyc = 0;
    int         n_ready0 = 0, n_wr = 0, n_valid = 0, n_errp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b, input int g);
        rx_b.push_back(b);
        rx_g.push_back(g);
    endtask

    task automatic push_frame(input logic [7:0] t, input logic [7:0] d, input int g, input int bad);
        push_rx(SYNC, g);
        push_rx(t, g);
        push_rx(d, g);
`ifdef UART_MSG_CHKSUM_EN
        push_rx((SYNC ^ t ^ d) ^ ((bad != 0) ? 8'h10 : 8'h00), g);
`else
        if (bad != 0) push_rx(8'h00, g);
`endif
    endtask

    // one clock cycle: drive rx, check outputs against the model, advance the model
    task automatic step();
        logic [1:0] e_rdy;
        logic       e_wr, g;
        logic [7:0] b;
        if (reset) begin
            rx_b.delete();
            rx_g.delete();
        end
        if (rx_b.size() > 0 && rx_g[0] == 0) begin
            rx_empty = 1'b0;
            r_data   = rx_b[0];
        end else begin
            rx_empty = 1'b1;
            r_data   = 8'($urandom);
            if (rx_b.size() > 0) rx_g[0] = rx_g[0] - 1;
        end
        #1;
        check_eq("rx_valid", rx_valid, exp_valid);
        check_eq("rx_err", rx_err, exp_err);
        check_eq("rx_tag", rx_tag, exp_tag);
        check_eq("rx_data", rx_data, exp_data);
        n_valid += int'(rx_valid);
        n_errp  += int'(rx_err);
        if (wchk_zero != 0) check_eq("w_data_rst", w_data, 8'h00);
        wchk_zero = 0;
        acc_flag  = 0;
        if (reset) begin
            check_eq("rst_ready", req_ready, 2'b00);
            check_eq("rst_wr", wr_uart, 1'b0);
            check_eq("rst_rd", rd_uart, 1'b0);
            txq.delete();
            fbuf.delete();
            tx_pend   = 0;
            last_gnt  = 1'b1;
            in_frame  = 0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_tag   = 8'h00;
            exp_data  = 8'h00;
            wchk_zero = 1;
        end else begin
            g = (req_valid == 2'b10) || (req_valid == 2'b11 && last_gnt == 1'b0);
            e_rdy = 2'b00;
            if (tx_pend == 0 && req_valid != 2'b00) e_rdy[g] = 1'b1;
            check_eq("req_ready", req_ready, e_rdy);
            n_ready0 += int'(req_ready[0]);
            e_wr = (tx_pend != 0) && !tx_full;
            check_eq("wr_uart", wr_uart, e_wr);
            if (tx_pend != 0) check_eq("w_data", w_data, txq[0]);
            if (e_wr) begin
                void'(txq.pop_front());
                tx_pend--;
                n_wr++;
            end
            if (e_rdy != 2'b00) begin
                txq.push_back(SYNC);
                txq.push_back(g ? req_tag1 : req_tag0);
                txq.push_back(g ? req_data1 : req_data0);
`ifdef UART_MSG_CHKSUM_EN
                txq.push_back(SYNC ^ (g ? req_tag1 : req_tag0) ^ (g ? req_data1 : req_data0));
`endif
                tx_pend  = FLEN;
                last_gnt = g;
                acc_flag = 1;
                gnt_log.push_back(int'(g));
            end
            check_eq("rd_uart", rd_uart, !rx_empty);
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (!rx_empty) begin
                b = rx_b.pop_front();
                void'(rx_g.pop_front());
                if (in_frame == 0) begin
                    if (b == SYNC) begin
                        in_frame = 1;
                        idle_cnt = 0;
                        fbuf.delete();
                    end
                end else begin
                    fbuf.push_back(b);
                    idle_cnt = 0;
                    if (fbuf.size() == FLEN - 1) begin
                        in_frame = 0;
`ifdef UART_MSG_CHKSUM_EN
                        if (fbuf[2] == (SYNC ^ fbuf[0] ^ fbuf[1])) begin
                            exp_valid = 1'b1; exp_tag = fbuf[0]; exp_data = fbuf[1];
                        end else begin
                            exp_err = 1'b1;
                        end
`else
                        exp_valid = 1'b1; exp_tag = fbuf[0]; exp_data = fbuf[1];
`endif
                    end
                end
            end else if (in_frame != 0) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    exp_err  = 1'b1;
                    in_frame = 0;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_acc(input int budget);
        int k = 0;
        do begin step(); k++; end while (acc_flag == 0 && k < budget);
        check_eq("accept_wait", acc_flag, 1);
    endtask

    task automatic wait_tx_idle(input int budget);
        int k = 0;
        while (tx_pend != 0 && k < budget) begin step(); k++; end
        check_eq("tx_idle_wait", tx_pend, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int k, t_first, t_last, c0;
        reset = 1'b1; req_valid = 2'b00; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
        req_tag0 = 8'h00; req_tag1 = 8'h00; req_data0 = 8'h00; req_data1 = 8'h00;
        repeat (2) @(negedge clk);
        apply_reset();

        // single request
        req_tag0 = 8'h12; req_data0 = 8'h34; req_valid = 2'b01; n_ready0 = 0; n_wr = 0;
        wait_acc(10);
        req_valid = 2'b00;
        wait_tx_idle(20);
        repeat (2) step();
        check_eq("single_ready0_cycles", n_ready0, 1);
        check_eq("single_bytes", n_wr, FLEN);

        // tie arbitration from reset pointer
        apply_reset();
        gnt_log.delete();
        req_tag0 = 8'hA0; req_data0 = 8'h0B; req_tag1 = 8'hB1; req_data1 = 8'h1C;
        req_valid = 2'b11; k = 0; t_first = 0; t_last = 0;
        while (gnt_log.size() < 4 && k < 100) begin
            c0 = cyc;
            step();
            if (acc_flag != 0 && gnt_log.size() == 1) t_first = c0;
            if (acc_flag != 0 && gnt_log.size() == 4) t_last = c0;
            k++;
        end
        req_valid = 2'b00;
        check_eq("tie_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check_eq("tie_order", gnt_log[i], i % 2);
        check_eq("tie_spacing", t_last - t_first, 3 * (FLEN + 1));
        wait_tx_idle(20);

        // backpressure during TAG
        req_tag0 = 8'h5C; req_data0 = 8'hC3; req_valid = 2'b01; n_wr = 0;
        wait_acc(10);
        req_valid = 2'b00;
        k = 0;
        while (tx_pend != FLEN - 1 && k < 10) begin step(); k++; end
        check_eq("bp_in_tag", tx_pend, FLEN - 1);
        tx_full = 1'b1;
        repeat (10) step();
        tx_full = 1'b0;
        wait_tx_idle(20);
        check_eq("bp_bytes", n_wr, FLEN);

        // rx stream with leading junk
        n_valid = 0; n_errp = 0;
        push_rx(8'h77, 0);
        push_frame(8'h01, 8'hFF, 0, 0);
        repeat (10) step();
        check_eq("stream_valid_cnt", n_valid, 1);
        check_eq("stream_err_cnt", n_errp, 0);
        check_eq("stream_tag", rx_tag, 8'h01);
        check_eq("stream_data", rx_data, 8'hFF);

        // rx timeout then recovery
        n_valid = 0; n_errp = 0;
        push_rx(SYNC, 0); push_rx(8'h01, 0);
        repeat (TO + 5) step();
        check_eq("to_err_cnt", n_errp, 1);
        check_eq("to_valid_cnt", n_valid, 0);
        push_frame(8'h02, 8'h03, 0, 0);
        repeat (10) step();
        check_eq("to_recover_valid", n_valid, 1);
        check_eq("to_recover_tag", rx_tag, 8'h02);
        check_eq("to_recover_data", rx_data, 8'h03);

        // randomized traffic on both directions
        for (int n = 0; n < 3000; n++) begin
            req_valid = 2'($urandom);
            req_tag0 = 8'($urandom); req_tag1 = 8'($urandom);
            req_data0 = 8'($urandom); req_data1 = 8'($urandom);
            tx_full = ($urandom_range(0, 3) == 0);
            if (rx_b.size() < 2) begin
                case ($urandom_range(0, 5))
                    0: push_rx(8'($urandom), $urandom_range(0, 2));
                    4: push_frame(8'($urandom), 8'($urandom), $urandom_range(0, 2), 1);
                    5: begin
                        push_rx(SYNC, 0);
                        push_rx(8'($urandom), 0);
                        case ($urandom_range(0, 2))
                            0: push_rx(8'($urandom), TO - 1);
                            1: push_rx(8'($urandom), TO);
                            default: push_rx(8'($urandom), TO + 3);
                        endcase
                    end
                    default: push_frame(8'($urandom), 8'($urandom), $urandom_range(0, 2), 0);
                endcase
            end
            step();
        end
        req_valid = 2'b00; tx_full = 1'b0;
        k = 0;
        while ((rx_b.size() > 0 || tx_pend != 0) && k < 500) begin step(); k++; end
        check_eq("drain_rx", rx_b.size(), 0);
        repeat (TO + 5) step();

        // reset while the DATA byte is pending
        req_tag0 = 8'h3C; req_data0 = 8'h4D; req_valid = 2'b01;
        wait_acc(10);
        req_valid = 2'b00;
        k = 0;
        while (tx_pend != FLEN - 2 && k < 10) begin step(); k++; end
        check_eq("rst_in_data", tx_pend, FLEN - 2);
        apply_reset();
        req_tag0 = 8'h11; req_data0 = 8'h22; req_valid = 2'b01;
        step();
        check_eq("post_rst_accept", acc_flag, 1);
        req_valid = 2'b00;
        wait_tx_idle(20);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
